// File: rtl/demux_buf_if.sv
// Stream bundle for demux_buf: one producer-side beat interface fanned out
// to NUM_OUT consumer lanes. The slave view belongs to the demux and the
// master view to whatever drives it.
interface demux_buf_if #(
    parameter int unsigned NUM_OUT = 4,
    parameter int unsigned DATA_W  = 8
);
    logic                        in_valid_i;
    logic                        in_ready_o;
    logic [DATA_W-1:0]           in_data_i;
    logic [NUM_OUT-1:0]          sel_i;
    logic [NUM_OUT-1:0]          out_valid_o;
    logic [NUM_OUT-1:0]          out_ready_i;
    logic [NUM_OUT*DATA_W-1:0]   out_data_o;

    modport slave (
        input  in_valid_i, in_data_i, sel_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o
    );

    modport master (
        output in_valid_i, in_data_i, sel_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o
    );
endinterface

// File: rtl/demux_buf.sv
// One-hot stream demultiplexer with a one-entry holding slot per output lane.
// A stalled lane only blocks the input while the input targets that lane.
// Beats with a non-one-hot select are accepted, dropped, flagged and counted.
module demux_buf #(
    parameter int unsigned NUM_OUT = 4,
    parameter int unsigned DATA_W  = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    demux_buf_if.slave          bus,
    output logic                sel_err_o,
    output logic [7:0]          drop_cnt_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    slot_state_e              state_q [NUM_OUT];
    slot_state_e              state_d [NUM_OUT];
    logic [DATA_W-1:0]        data_q  [NUM_OUT];
    logic [DATA_W-1:0]        data_d  [NUM_OUT];
    logic                     sel_err_q, sel_err_d;
    logic [7:0]               drop_cnt_q, drop_cnt_d;

    logic                     sel_valid;
    logic                     slot_free;
    logic                     in_ready;
    logic                     accept;
    logic [NUM_OUT-1:0]       drain;
    logic [NUM_OUT-1:0]       out_valid;
    logic [NUM_OUT*DATA_W-1:0] out_data;

    // Input-side handshake: ready depends only on the select and the
    // selected lane's consumer ready, never on in_valid_i.
    always_comb begin
        sel_valid = $onehot(bus.sel_i);
        slot_free = 1'b0;
        drain     = '0;
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
            drain[k] = (state_q[k] == FULL) && bus.out_ready_i[k];
            // Select is one-hot when this result is used, so the OR picks
            // exactly the targeted lane.
            if (bus.sel_i[k] && ((state_q[k] == EMPTY) || drain[k])) begin
                slot_free = 1'b1;
            end
        end
        in_ready = reset_n && (sel_valid ? slot_free : 1'b1);
        accept   = bus.in_valid_i && in_ready;
    end

    // Per-lane slot next state: fill wins over drain, so drain+fill reloads.
    always_comb begin
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            if (accept && sel_valid && bus.sel_i[k]) begin
                state_d[k] = FULL;
                data_d[k]  = bus.in_data_i;
            end else if (drain[k]) begin
                state_d[k] = EMPTY;
            end
        end
    end

    // Dropped-beat flag and saturating drop counter.
    always_comb begin
        sel_err_d  = accept && !sel_valid;
        drop_cnt_d = drop_cnt_q;
        if (sel_err_d && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // State registers; reset discards any held beats.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < NUM_OUT; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
            end
            sel_err_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_OUT; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
            sel_err_q  <= sel_err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Flatten lane registers onto the output buses.
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
            out_valid[k]                   = (state_q[k] == FULL);
            out_data[k*DATA_W +: DATA_W]   = data_q[k];
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.out_data_o  = out_data;
    assign sel_err_o       = sel_err_q;
    assign drop_cnt_o      = drop_cnt_q;

endmodule

// File: tb/tb_demux_buf.sv
// Directed bench for demux_buf: reset, single beat hold, blocking with
// same-cycle drain+fill, lane independence, invalid selects, counter
// saturation and asynchronous reset mid-operation.
module tb_demux_buf;

    localparam int unsigned NUM_OUT = 4;
    localparam int unsigned DATA_W  = 8;

    logic       clk;
    logic       reset_n;
    logic       sel_err;
    logic [7:0] drop_cnt;

    int unsigned n_tests;
    int unsigned n_fail;

    demux_buf_if #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W)) bus ();

    demux_buf #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .sel_err_o  (sel_err),
        .drop_cnt_o (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Reset held with a beat offered: nothing may be accepted.
        reset_n         = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.in_data_i   = 8'h00;
        bus.sel_i       = 4'b0001;
        bus.out_ready_i = 4'b0000;
        #3;
        check("rst_in_ready", bus.in_ready_o, 0);
        check("rst_out_valid", bus.out_valid_o, 4'b0000);
        check("rst_out_data", bus.out_data_o, 32'h0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_sel_err", sel_err, 0);
        step();
        step();
        bus.in_valid_i = 1'b0;
        reset_n        = 1'b1;
        #1;
        check("post_rst_in_ready", bus.in_ready_o, 1);

        // Single beat to lane 1, then stall for 5 cycles.
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 8'hA5;
        bus.sel_i      = 4'b0010;
        step();
        bus.in_valid_i = 1'b0;
        #1;
        check("single_valid", bus.out_valid_o, 4'b0010);
        check("single_data", bus.out_data_o[15:8], 8'hA5);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", bus.out_valid_o, 4'b0010);
            check("hold_data", bus.out_data_o[15:8], 8'hA5);
        end

        // Lane 1 full: blocked until its consumer becomes ready.
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 8'h3C;
        bus.sel_i      = 4'b0010;
        #1;
        check("blocked_ready", bus.in_ready_o, 0);
        bus.out_ready_i = 4'b0010;
        #1;
        check("drain_fill_ready", bus.in_ready_o, 1);
        step();
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 4'b0000;
        #1;
        check("drain_fill_valid", bus.out_valid_o, 4'b0010);
        check("drain_fill_data", bus.out_data_o[15:8], 8'h3C);

        // Lane 1 stalled; lanes 0 and 3 still accept.
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 8'h11;
        bus.sel_i      = 4'b0001;
        #1;
        check("indep_ready0", bus.in_ready_o, 1);
        step();
        bus.in_data_i = 8'h22;
        bus.sel_i     = 4'b1000;
        #1;
        check("indep_ready3", bus.in_ready_o, 1);
        step();
        bus.in_valid_i = 1'b0;
        #1;
        check("indep_valid", bus.out_valid_o, 4'b1011);
        check("indep_data", bus.out_data_o, 32'h22_00_3C_11);
        bus.out_ready_i = 4'hF;
        step();
        bus.out_ready_i = 4'h0;
        #1;
        check("indep_drained", bus.out_valid_o, 4'b0000);

        // Park a beat in lane 2, then send two invalid-select beats.
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 8'h77;
        bus.sel_i      = 4'b0100;
        step();
        bus.in_data_i = 8'hEE;
        bus.sel_i     = 4'b0000;
        #1;
        check("inv0_ready", bus.in_ready_o, 1);
        step();
        bus.sel_i = 4'b0110;
        #1;
        check("inv1_err", sel_err, 1);
        check("inv1_cnt", drop_cnt, 1);
        check("inv_multi_ready", bus.in_ready_o, 1);
        step();
        bus.in_valid_i = 1'b0;
        #1;
        check("inv2_err", sel_err, 1);
        check("inv2_cnt", drop_cnt, 2);
        check("inv_valid", bus.out_valid_o, 4'b0100);
        check("inv_data", bus.out_data_o[23:16], 8'h77);
        step();
        check("inv_err_clear", sel_err, 0);
        check("inv_cnt_hold", drop_cnt, 2);

        // 260 more invalid beats: counter pins at 255.
        bus.in_valid_i = 1'b1;
        bus.sel_i      = 4'b0000;
        for (int i = 0; i < 260; i++) begin
            step();
            if (i == 252) check("cnt_before_sat", drop_cnt, 8'd255);
        end
        bus.in_valid_i = 1'b0;
        step();
        check("sat_cnt", drop_cnt, 8'd255);
        check("sat_valid", bus.out_valid_o, 4'b0100);

        // Asynchronous reset with lane 2 full.
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", bus.out_valid_o, 4'b0000);
        check("arst_data", bus.out_data_o, 32'h0);
        check("arst_cnt", drop_cnt, 0);
        check("arst_ready", bus.in_ready_o, 0);
        step();
        reset_n = 1'b1;
        #1;
        check("arst_release_ready", bus.in_ready_o, 1);
        step();
        check("arst_release_valid", bus.out_valid_o, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
